// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state enum, defaults, width helpers and block type for the data cache
// Used by dcache_ctrl, whose optional counters are enabled with DCACHE_STATS_EN.
package cache_pkg;

  localparam int DEFAULT_LINES = 8;
  localparam int DEFAULT_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  typedef logic [DEFAULT_WORDS-1:0][31:0] block_t;

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int offset_w(input int words);
    return $clog2(words) + 2;
  endfunction

  function automatic int tag_w(input int lines, input int words);
    return 32 - index_w(lines) - offset_w(words);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/dirty/tag/data storage with one read port and one write port
// Write port does either a single word store (sets dirty) or a whole block fill (clears dirty).
module dcache_array
  import cache_pkg::*;
#(
  parameter int  LINES    = DEFAULT_LINES,
  parameter int  WORDS    = DEFAULT_WORDS,
  localparam int INDEX_W  = index_w(LINES),
  localparam int OFFSET_W = offset_w(WORDS),
  localparam int TAG_W    = tag_w(LINES, WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INDEX_W-1:0]   rd_index,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [32*WORDS-1:0]  rd_block,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic                 wr_word_en,
  input  logic [OFFSET_W-3:0]  wr_word_sel,
  input  logic [31:0]          wr_word,
  input  logic                 wr_fill_en,
  input  logic [TAG_W-1:0]     wr_fill_tag,
  input  logic [32*WORDS-1:0]  wr_fill_block
);

  logic [LINES-1:0]        valid_q;
  logic [LINES-1:0]        dirty_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [WORDS-1:0][31:0]  data_q [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_block = data_q[rd_index];

  // Only the status bits are reset; tags and data are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_fill_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= 1'b0;
    end else if (wr_word_en) begin
      dirty_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fill_en) begin
      tag_q[wr_index]  <= wr_fill_tag;
      data_q[wr_index] <= wr_fill_block;
    end else if (wr_word_en) begin
      data_q[wr_index][wr_word_sel] <= wr_word;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int  LINES    = DEFAULT_LINES,
  parameter int  WORDS    = DEFAULT_WORDS,
  localparam int INDEX_W  = index_w(LINES),
  localparam int OFFSET_W = offset_w(WORDS),
  localparam int TAG_W    = tag_w(LINES, WORDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_busywait,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31-OFFSET_W:0]   mem_addr,
  output logic [32*WORDS-1:0]    mem_wdata,
  input  logic [32*WORDS-1:0]    mem_rdata,
  input  logic                   mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
`endif
);

  cache_state_t state_q, state_d;

  logic [TAG_W-1:0]       addr_tag;
  logic [INDEX_W-1:0]     addr_index;
  logic [OFFSET_W-3:0]    addr_word;
  logic                   addr_unused;

  logic                   line_valid;
  logic                   line_dirty;
  logic [TAG_W-1:0]       line_tag;
  logic [32*WORDS-1:0]    line_block;
  logic [WORDS-1:0][31:0] line_words;

  logic                   access;
  logic                   hit;
  logic                   word_we;
  logic                   fill_we;
  logic                   rd_fire;
  logic [31:0]            hit_word;
  logic [31:0]            rdata_q;

  assign addr_tag    = cpu_addr[31 -: TAG_W];
  assign addr_index  = cpu_addr[OFFSET_W +: INDEX_W];
  assign addr_word   = cpu_addr[2 +: OFFSET_W-2];
  assign addr_unused = ^cpu_addr[1:0];

  assign access     = cpu_read | cpu_write;
  assign hit        = line_valid & (line_tag == addr_tag);
  assign line_words = line_block;
  assign hit_word   = line_words[addr_word];

  dcache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk           (clk),
    .reset         (reset),
    .rd_index      (addr_index),
    .rd_valid      (line_valid),
    .rd_dirty      (line_dirty),
    .rd_tag        (line_tag),
    .rd_block      (line_block),
    .wr_index      (addr_index),
    .wr_word_en    (word_we),
    .wr_word_sel   (addr_word),
    .wr_word       (cpu_wdata),
    .wr_fill_en    (fill_we),
    .wr_fill_tag   (addr_tag),
    .wr_fill_block (mem_rdata)
  );

  // A store wins over a simultaneous load, so reads only fire when cpu_write is low.
  always_comb begin
    state_d      = state_q;
    cpu_busywait = 1'b0;
    word_we      = 1'b0;
    fill_we      = 1'b0;
    rd_fire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (hit) begin
            word_we = cpu_write;
            rd_fire = ~cpu_write;
          end else begin
            cpu_busywait = 1'b1;
            state_d      = (line_valid & line_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        cpu_busywait = 1'b1;
        if (mem_ack) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_busywait = 1'b1;
        if (mem_ack) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mem_req <= (state_d != IDLE);
      mem_we  <= (state_d == WRITEBACK);
      if (rd_fire) rdata_q <= hit_word;
    end
  end

  assign cpu_rdata = rd_fire ? hit_word : rdata_q;
  assign mem_addr  = (state_q == WRITEBACK) ? {line_tag, addr_index} : {addr_tag, addr_index};
  assign mem_wdata = line_block;

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_q == IDLE && access && hit && hit_count != '1)
        hit_count <= hit_count + 32'd1;
      if (state_q == IDLE && state_d != IDLE && miss_count != '1)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl against a flat-memory reference model
// Counter outputs are connected and checked when DCACHE_STATS_EN is defined.
module tb_dcache_ctrl;
  import cache_pkg::*;

  localparam int LINES = DEFAULT_LINES;
  localparam int WORDS = DEFAULT_WORDS;
  localparam int OFF   = offset_w(WORDS);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cpu_read, cpu_write;
  logic [31:0]          cpu_addr, cpu_wdata, cpu_rdata;
  logic                 cpu_busywait;
  logic                 mem_req, mem_we, mem_ack;
  logic [31-OFF:0]      mem_addr;
  logic [32*WORDS-1:0]  mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]          hit_count, miss_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_busywait(cpu_busywait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // Reference: flat word memory as the CPU sees it, plus which block each line holds.
  logic [31:0] golden   [int unsigned];
  logic [31:0] exp_mem  [int unsigned];
  logic [31:0] phys_mem [int unsigned];
  int unsigned m_tag   [LINES];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  int          exp_hits = 0;
  int          exp_miss = 0;

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] model_word(input int unsigned wa);
    if (golden.exists(wa)) return golden[wa];
    if (exp_mem.exists(wa)) return exp_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [32*WORDS-1:0] phys_block(input int unsigned ba);
    block_t b;
    for (int i = 0; i < WORDS; i++)
      b[i] = phys_mem.exists(ba*WORDS+i) ? phys_mem[ba*WORDS+i] : init_word(ba*WORDS+i);
    return b;
  endfunction

  typedef struct {
    int unsigned         addr;
    logic [32*WORDS-1:0] data;
  } wb_rec_t;

  wb_rec_t     wb_q[$];
  int unsigned al_q[$];
  int          ack_delay = 1;
  bit          spurious = 0;

  // Memory responder: acks the request in its ack_delay-th cycle (random 1..4 when 0).
  initial begin : responder
    int                  req_cyc;
    int                  cur_delay;
    logic [31-OFF:0]     req_addr;
    logic                req_we;
    logic [32*WORDS-1:0] req_wdata;
    wb_rec_t             r;
    req_cyc = 0;
    cur_delay = 1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (reset || !mem_req) begin
        req_cyc = 0;
        if (spurious && !reset) begin
          mem_ack = 1'b1;
          mem_rdata = {4{$urandom}};
          spurious = 0;
        end
      end else begin
        req_cyc++;
        if (req_cyc == 1) begin
          req_addr  = mem_addr;
          req_we    = mem_we;
          req_wdata = mem_wdata;
          cur_delay = (ack_delay > 0) ? ack_delay : int'($urandom_range(1, 4));
        end else begin
          checks++;
          if (mem_addr !== req_addr || mem_we !== req_we || (req_we && mem_wdata !== req_wdata)) begin
            failures++;
            $display("FAIL mem_hold: addr=%h we=%b, required addr=%h we=%b", mem_addr, mem_we, req_addr, req_we);
          end
        end
        if (req_cyc == cur_delay) begin
          mem_ack = 1'b1;
          if (req_we) begin
            r.addr = int'(req_addr);
            r.data = req_wdata;
            wb_q.push_back(r);
            for (int i = 0; i < WORDS; i++) phys_mem[r.addr*WORDS+i] = req_wdata[32*i +: 32];
          end else begin
            al_q.push_back(int'(req_addr));
            mem_rdata = phys_block(int'(req_addr));
          end
          req_cyc = 0;
        end
      end
    end
  end

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int exp_busy, input string name);
    int unsigned blk, idx, tg, wa, old_blk;
    bit          hit_p, wb_p, done;
    int          busy;
    logic [31:0] exp_rd;
    block_t      exp_blk;
    wb_rec_t     r;
    blk   = addr >> OFF;
    idx   = blk % LINES;
    tg    = blk / LINES;
    wa    = addr >> 2;
    hit_p = m_valid[idx] && m_tag[idx] == tg;
    wb_p  = !hit_p && m_valid[idx] && m_dirty[idx];
    old_blk = m_tag[idx] * LINES + idx;
    exp_rd = model_word(wa);
    @(posedge clk); #1;
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
    busy = 0;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (cpu_busywait) busy++;
      else done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: busywait still 1 after %0d cycles, required release", name, busy);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench stopped");
    end
    checks++;
    if (exp_busy >= 0) begin
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy, exp_busy);
      end
    end else if ((busy != 0) !== !hit_p) begin
      failures++;
      $display("FAIL %s hit_miss: busy cycles %0d, required miss=%0b", name, busy, !hit_p);
    end
    if (rd && !wr) begin
      checks++;
      if (cpu_rdata !== exp_rd) begin
        failures++;
        $display("FAIL %s rdata: got %h, required %h", name, cpu_rdata, exp_rd);
      end
    end
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s mem_req_idle: got %b, required 0", name, mem_req);
    end
    checks++;
    if (wb_q.size() !== int'(wb_p)) begin
      failures++;
      $display("FAIL %s writeback_count: got %0d, required %0d", name, wb_q.size(), wb_p);
    end
    if (wb_p && wb_q.size() > 0) begin
      r = wb_q.pop_front();
      for (int i = 0; i < WORDS; i++) exp_blk[i] = model_word(old_blk*WORDS+i);
      checks++;
      if (r.addr !== old_blk || r.data !== exp_blk) begin
        failures++;
        $display("FAIL %s writeback: addr=%h data=%h, required addr=%h data=%h", name, r.addr, r.data, old_blk, exp_blk);
      end
    end
    wb_q.delete();
    checks++;
    if (al_q.size() !== int'(!hit_p)) begin
      failures++;
      $display("FAIL %s allocate_count: got %0d, required %0d", name, al_q.size(), !hit_p);
    end
    if (!hit_p && al_q.size() > 0) begin
      checks++;
      if (al_q[0] !== blk) begin
        failures++;
        $display("FAIL %s allocate_addr: got %h, required %h", name, al_q[0], blk);
      end
    end
    al_q.delete();
    @(posedge clk); #1;
    cpu_read = 0; cpu_write = 0;
    if (rd && !wr) begin
      @(negedge clk);
      checks++;
      if (cpu_rdata !== exp_rd || cpu_busywait !== 1'b0) begin
        failures++;
        $display("FAIL %s rdata_hold: got %h busy=%b, required %h busy=0", name, cpu_rdata, cpu_busywait, exp_rd);
      end
    end
    if (!hit_p) begin
      if (wb_p)
        for (int i = 0; i < WORDS; i++) exp_mem[old_blk*WORDS+i] = model_word(old_blk*WORDS+i);
      m_valid[idx] = 1; m_tag[idx] = tg; m_dirty[idx] = 0;
      exp_miss++;
    end
    exp_hits++;
    if (wr) begin
      golden[wa] = wd;
      m_dirty[idx] = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1; cpu_read = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < LINES; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; end
    @(negedge clk);
    checks++;
    if (cpu_busywait !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: busy=%b req=%b we=%b rdata=%h, required 0 0 0 0", cpu_busywait, mem_req, mem_we, cpu_rdata);
    end
  endtask

  task automatic test_clean_miss();
    ack_delay = 3;
    do_access(1, 0, 32'h40, 32'h0, 4, "clean_miss_0x40");
    do_access(1, 0, 32'h44, 32'h0, 0, "hit_0x44");
  endtask

  task automatic test_write_hit();
    do_access(0, 1, 32'h40, 32'hDEADBEEF, 0, "write_hit_0x40");
    do_access(1, 0, 32'h40, 32'h0, 0, "read_back_0x40");
  endtask

  task automatic test_read_write_both();
    do_access(1, 1, 32'h48, 32'h12345678, 0, "both_0x48");
    do_access(1, 0, 32'h48, 32'h0, 0, "read_back_0x48");
  endtask

  task automatic test_dirty_evict();
    ack_delay = 2;
    do_access(1, 0, 32'h140, 32'h0, 5, "dirty_miss_0x140");
  endtask

  task automatic test_idle_ack();
    @(posedge clk); #1;
    spurious = 1;
    repeat (3) @(posedge clk);
    do_access(1, 0, 32'h148, 32'h0, 0, "after_idle_ack_0x148");
  endtask

  task automatic test_reset_mid();
    bit seen;
    ack_delay = 20;
    @(posedge clk); #1;
    cpu_read = 1; cpu_addr = 32'h40;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = mem_req;
    end
    checks++;
    if (seen !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL alloc_start: req=%b we=%b, required 1 0", seen, mem_we);
    end
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0; cpu_read = 0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || cpu_busywait !== 1'b0 || cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: req=%b busy=%b rdata=%h, required 0 0 0", mem_req, cpu_busywait, cpu_rdata);
    end
    checks++;
    if (wb_q.size() != 0 || al_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_acks: wb=%0d al=%0d, required 0 0", wb_q.size(), al_q.size());
    end
    for (int i = 0; i < LINES; i++) begin
      if (m_valid[i] && m_dirty[i])
        for (int w = 0; w < WORDS; w++) golden.delete((m_tag[i]*LINES + i)*WORDS + w);
      m_valid[i] = 0; m_dirty[i] = 0;
    end
    exp_hits = 0;
    exp_miss = 0;
    ack_delay = 2;
    do_access(1, 0, 32'h40, 32'h0, 3, "miss_after_reset_0x40");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int          op;
    ack_delay = 0;
    for (int n = 0; n < 200; n++) begin
      addr = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
           | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, addr, $urandom, -1, "random");
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    checks++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_miss)) begin
      failures++;
      $display("FAIL stats: hits=%0d misses=%0d, required %0d %0d", hit_count, miss_count, exp_hits, exp_miss);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_read_write_both();
    test_dirty_evict();
    test_idle_ack();
    test_reset_mid();
    test_random();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
